// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchroniser, shared prescaler sample tick and
// per-channel agreement counter, with edge strobes and sticky change flags.
module debounce_bank #(
    parameter int              CH   = 8,
    parameter int              DIV  = 50000,
    parameter int              CNT  = 4,
    parameter logic [CH-1:0]   INIT = {CH{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sig_i,
    input  logic [CH-1:0] evt_clr_i,
    output logic [CH-1:0] sig_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o,
    output logic [CH-1:0] evt_o,
    output logic          tick_o
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            CW       = $clog2(CNT + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW:0]   CNT_LAST = (CW + 1)'(CNT);

    logic [PW-1:0] presc_p0;
    logic [CH-1:0] sync_p0;
    logic [CH-1:0] sync_p1;
    logic [CW-1:0] cnt_p2 [CH];
    logic [CH-1:0] flip;

    // Stage 0: shared prescaler producing the registered sample strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_p0 <= '0;
            tick_o   <= 1'b0;
        end else begin
            tick_o   <= (presc_p0 == PRE_LAST);
            presc_p0 <= (presc_p0 == PRE_LAST) ? '0 : presc_p0 + 1'b1;
        end
    end

    // Stage 0/1: two-flop synchroniser for the asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= INIT;
            sync_p1 <= INIT;
        end else begin
            sync_p0 <= sig_i;
            sync_p1 <= sync_p0;
        end
    end

    // A channel flips on the tick that completes CNT consecutive disagreeing samples
    always_comb begin
        flip = '0;
        for (int n = 0; n < CH; n++) begin
            if (tick_o && (sync_p1[n] != sig_o[n]) &&
                (({1'b0, cnt_p2[n]} + 1'b1) >= CNT_LAST)) begin
                flip[n] = 1'b1;
            end
        end
    end

    // Stage 2: counters, debounced level, strobes and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_o  <= INIT;
            rise_o <= '0;
            fall_o <= '0;
            evt_o  <= '0;
            for (int n = 0; n < CH; n++) begin
                cnt_p2[n] <= '0;
            end
        end else begin
            sig_o  <= sig_o ^ flip;
            rise_o <= flip & sync_p1;
            fall_o <= flip & ~sync_p1;
            // A new strobe wins over a simultaneous clear
            evt_o  <= flip | (evt_o & ~evt_clr_i);
            for (int n = 0; n < CH; n++) begin
                if (tick_o) begin
                    if ((sync_p1[n] == sig_o[n]) || flip[n]) begin
                        cnt_p2[n] <= '0;
                    end else begin
                        cnt_p2[n] <= cnt_p2[n] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expectations are queued against absolute
// cycle numbers when stimulus is planned and compared on the falling clock edge.
module tb_debounce_bank;

    typedef struct {
        int          t;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sig = 4'hF;
    logic [3:0] clr = 4'h0;
    logic [3:0] sig1 = 4'hF;
    logic [3:0] clr1 = 4'h0;

    logic [3:0] sig_o, rise_o, fall_o, evt_o;
    logic       tick_o;
    logic [3:0] sig1_o, rise1_o, fall1_o, evt1_o;
    logic       tick1_o;

    int   abs_cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    debounce_bank #(.CH(4), .DIV(4), .CNT(3), .INIT(4'hF)) dut (
        .clk(clk), .reset(reset), .sig_i(sig), .evt_clr_i(clr),
        .sig_o(sig_o), .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o), .tick_o(tick_o)
    );

    debounce_bank #(.CH(4), .DIV(1), .CNT(1), .INIT(4'hF)) dut1 (
        .clk(clk), .reset(reset), .sig_i(sig1), .evt_clr_i(clr1),
        .sig_o(sig1_o), .rise_o(rise1_o), .fall_o(fall1_o), .evt_o(evt1_o), .tick_o(tick1_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) abs_cyc <= abs_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0: return 32'(sig_o);
            1: return 32'(rise_o);
            2: return 32'(fall_o);
            3: return 32'(evt_o);
            4: return 32'(tick_o);
            5: return 32'(sig1_o);
            6: return 32'(fall1_o);
            7: return 32'(tick1_o);
            8: return 32'(rise1_o);
            9: return 32'(evt1_o);
            default: return '0;
        endcase
    endfunction

    // Queue an expectation for cycle k of the current reset timeline, kept sorted by time
    task automatic expect_at(input int k, input int sel, input logic [31:0] e, input string tag);
        exp_t it;
        int   i;
        it.t   = base + k;
        it.sel = sel;
        it.exp = e;
        it.tag = $sformatf("%s@%0d", tag, k);
        i = sb.size();
        while (i > 0 && sb[i-1].t > it.t) i--;
        sb.insert(i, it);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t <= abs_cyc) begin
            exp_t it;
            it = sb.pop_front();
            if (it.t < abs_cyc) check({it.tag, "_late"}, 32'(abs_cyc), 32'(it.t));
            else                check(it.tag, probe(it.sel), it.exp);
        end
    end

    task automatic reset_on();
        @(negedge clk);
        reset = 1'b1;
        base  = abs_cyc + 1;
    endtask

    task automatic reset_off(input logic [3:0] s, input logic [3:0] s1);
        @(negedge clk);
        reset = 1'b0;
        sig   = s;
        sig1  = s1;
        clr   = 4'h0;
    endtask

    task automatic at_cycle(input int k);
        while (abs_cyc < base + k) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Channel 0 falls then rises with clear held (set wins); DIV=1/CNT=1 instance on ch3
        reset_on();
        expect_at(0, 0, 4'hF, "a_rst_sig");  expect_at(0, 1, 0, "a_rst_rise");
        expect_at(0, 2, 0, "a_rst_fall");    expect_at(0, 3, 0, "a_rst_evt");
        expect_at(0, 4, 0, "a_rst_tick");    expect_at(0, 5, 4'hF, "d1_rst_sig");
        expect_at(0, 6, 0, "d1_rst_fall");   expect_at(0, 7, 0, "d1_rst_tick");
        expect_at(0, 8, 0, "d1_rst_rise");   expect_at(0, 9, 0, "d1_rst_evt");
        expect_at(1, 7, 1, "d1_tick");
        expect_at(2, 5, 4'hF, "d1_sig");     expect_at(2, 6, 0, "d1_fall");
        expect_at(3, 5, 4'h7, "d1_sig");     expect_at(3, 6, 4'h8, "d1_fall");
        expect_at(4, 5, 4'h7, "d1_sig");     expect_at(4, 6, 0, "d1_fall");
        expect_at(3, 4, 0, "a_tick");        expect_at(4, 4, 1, "a_tick");
        expect_at(5, 4, 0, "a_tick");        expect_at(8, 4, 1, "a_tick");
        expect_at(12, 0, 4'hF, "a_sig");
        expect_at(13, 0, 4'hE, "a_sig");     expect_at(13, 2, 4'h1, "a_fall");
        expect_at(13, 1, 0, "a_rise");       expect_at(13, 3, 4'h1, "a_evt");
        expect_at(14, 2, 0, "a_fall");       expect_at(14, 3, 4'h1, "a_evt");
        expect_at(20, 3, 4'h1, "a_evt");     expect_at(21, 3, 0, "a_evt_clr");
        expect_at(24, 0, 4'hE, "a_sig");     expect_at(24, 1, 0, "a_rise");
        expect_at(25, 0, 4'hF, "a_sig");     expect_at(25, 1, 4'h1, "a_rise");
        expect_at(25, 3, 4'h1, "a_evt_setwins"); expect_at(25, 2, 0, "a_fall");
        expect_at(26, 1, 0, "a_rise");       expect_at(26, 3, 0, "a_evt_clr2");
        reset_off(4'hE, 4'h7);
        at_cycle(13); sig = 4'hF;
        at_cycle(20); clr = 4'h1;
        at_cycle(26); clr = 4'h0;
        drain();

        // Channel 1 low for a single sample only: no flip
        reset_on();
        for (int k = 1; k <= 20; k++) begin
            expect_at(k, 0, 4'hF, "b_sig");
            expect_at(k, 2, 0, "b_fall");
        end
        expect_at(20, 3, 0, "b_evt");
        reset_off(4'hD, 4'hF);
        at_cycle(5); sig = 4'hF;
        drain();

        // Channel 2 bounces: low, low, high, then low -> flips at the sixth tick
        reset_on();
        for (int k = 1; k <= 24; k++) begin
            expect_at(k, 0, 4'hF, "c_sig");
            expect_at(k, 2, 0, "c_fall");
        end
        expect_at(25, 0, 4'hB, "c_sig");  expect_at(25, 2, 4'h4, "c_fall");
        expect_at(25, 3, 4'h4, "c_evt");
        for (int k = 26; k <= 40; k++) expect_at(k, 2, 0, "c_fall");
        reset_off(4'hB, 4'hF);
        at_cycle(8);  sig = 4'hF;
        at_cycle(11); sig = 4'hB;
        drain();

        // Reset mid-count discards the partial count and restarts the prescaler
        reset_on();
        expect_at(0, 3, 0, "d_rst_evt");
        expect_at(9, 0, 4'hF, "d_sig_precount");
        expect_at(10, 0, 4'hF, "d_sig_precount");
        reset_off(4'hE, 4'hF);
        at_cycle(10);
        reset_on();
        expect_at(0, 0, 4'hF, "d_rst_sig");  expect_at(0, 1, 0, "d_rst_rise");
        expect_at(0, 2, 0, "d_rst_fall");    expect_at(0, 3, 0, "d_rst_evt2");
        expect_at(0, 4, 0, "d_rst_tick");    expect_at(1, 4, 0, "d_tick");
        expect_at(3, 4, 0, "d_tick");        expect_at(4, 4, 1, "d_tick");
        expect_at(5, 0, 4'hF, "d_sig");      expect_at(8, 0, 4'hF, "d_sig");
        expect_at(12, 0, 4'hF, "d_sig");
        expect_at(13, 0, 4'hE, "d_sig");     expect_at(13, 2, 4'h1, "d_fall");
        reset_off(4'hE, 4'hF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel input debouncer for slow board-level inputs such as push-buttons, jumpers and presence/fault lines. Each raw input goes through a two-flop synchroniser and is then sampled on a shared prescaler tick. A channel's output changes only after a configurable number of consecutive agreeing samples. Per-channel edge strobes and sticky event flags feed the register/control logic. The whole block runs on the system clock; it uses a clock-enable tick, not a derived clock.

## Interface
- CH, 8: number of independent channels (1..32).
- DIV, 50000: prescaler period in clk cycles between sample ticks (>=1).
- CNT, 4: consecutive disagreeing samples required to flip an output (1..255).
- INIT, {CH{1'b1}}: per-channel reset value of the synchroniser and output (CH bits).

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_i  in  CH  raw asynchronous inputs.
- sig_o  out  CH  debounced levels.
- rise_o  out  CH  one-cycle pulse when sig_o[n] goes 0->1.
- fall_o  out  CH  one-cycle pulse when sig_o[n] goes 1->0.
- evt_o  out  CH  sticky change flag, set on any rise/fall.
- evt_clr_i  in  CH  per-channel clear for evt_o (level, sampled each cycle).
- tick_o  out  1  registered sample strobe, high one cycle every DIV cycles.

## Operation
- Reset (reset=1 at an edge) forces the following values:
  - prescaler = 0, tick_o = 0;
  - sync stages = INIT, sig_o = INIT;
  - all channel counters = 0;
  - rise_o = fall_o = evt_o = 0.
- Synchroniser: two flops per channel, sync1 <= sig_i and sync2 <= sync1. Only sync2 is used downstream.
- Prescaler:
  - Width clog2(DIV), minimum 1.
  - Counts 0..DIV-1 and wraps to 0.
  - tick_o <= (prescaler == DIV-1). With DIV=1, tick_o is 1 on every cycle after reset.
- Channel counter: width clog2(CNT+1). It is evaluated only at edges where tick_o==1 and holds otherwise.
  - sync2 == sig_o: counter <= 0.
  - sync2 != sig_o and counter+1 < CNT: counter <= counter+1.
  - sync2 != sig_o and counter+1 == CNT: sig_o <= sync2, counter <= 0. In the same edge, rise_o or fall_o <= 1 according to the new level.
- rise_o and fall_o are 0 on every other edge, so each strobe is exactly one cycle wide and coincides with the first cycle of the new sig_o level.
- A single agreeing sample between disagreeing ones clears the counter. Bounce shorter than CNT ticks never reaches sig_o.
- evt_o[n] update:
  - If rise_o[n] or fall_o[n] is being set at the edge, evt_o[n] <= 1; set wins over a simultaneous evt_clr_i[n].
  - Otherwise, if evt_clr_i[n] is high, evt_o[n] <= 0.
  - Otherwise evt_o[n] holds.
- Channels are fully independent; only the prescaler is shared.

## Timing
- Cycle k is the interval after the k-th rising edge following the edge that sampled reset=1 then 0.
- tick_o is high in cycles DIV, 2*DIV, 3*DIV, … Channel evaluation therefore happens at edges DIV+1, 2*DIV+1, …
- Synchroniser latency: a sig_i change set up before edge m is visible on sync2 after edge m+1.
- Input-to-output latency for a stable level change:
  - minimum 2 + (CNT-1)*DIV + 1 cycles;
  - maximum 2 + CNT*DIV cycles.
- Reset asserted mid-count discards any partial count; sig_o returns to INIT with no strobes.
- No combinational path exists from any input to any output.

## Test plan
- CH=4, DIV=4, CNT=3, INIT=4'hF; drive sig_i=4'hE before edge 1 -> samples at edges 5, 9 and 13 give counts 1, 2 and flip. sig_o=4'hE from cycle 13, fall_o=4'h1 in cycle 13 only, evt_o[0]=1 from cycle 13, rise_o stays 0.
- Same config; hold sig_i[1]=0 for edges 1..5, then 1 -> count reaches 1 at edge 5, clears at edge 9. sig_o[1] stays 1, and fall_o[1] and evt_o[1] stay 0.
- Same config; sig_i[2] low during ticks 1 and 2, high during tick 3, then low -> no change at ticks 1..3. sig_o[2] falls only at the third consecutive low sample (tick 6); one fall_o pulse total.
- Same config; after the case-1 fall, drive sig_i[0]=1 and hold evt_clr_i[0]=1 through the rising flip -> evt_o[0] is 1 in the rise_o cycle (set wins). It clears one cycle later while evt_clr_i stays high.
- Same config; assert reset for one edge while a channel's count=2 -> next cycle sig_o=4'hF, rise_o=fall_o=evt_o=0, tick_o=0. The next tick_o occurs in cycle 4 after release.
- DIV=1, CNT=1: sig_i[3] 1->0 before edge 1 -> sig_o[3]=0 and fall_o[3]=1 in cycle 3, and fall_o[3]=0 in cycle 4.
